// File: rtl/obstacle_sched_pkg.sv
// Shared types and defaults for the per-scanline obstacle scheduler.
package obstacle_sched_pkg;

  localparam int SLOT_NUM        = 4;
  localparam int OBSTACLE_HEIGHT = 20;
  localparam int OBSTACLE_WIDTH  = 10;
  localparam int ROW_WIDTH       = 5;
  localparam int ID_WIDTH        = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;

endpackage

// File: rtl/obstacle_line_scheduler_if.sv
// Obstacle table read bus: scheduler issues index, table returns entry one cycle later.
interface obstacle_line_scheduler_if #(
  parameter int PHY_WIDTH       = 14,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int IDX_WIDTH       = 4
);

  logic                       tbl_rd_en;
  logic [IDX_WIDTH-1:0]       tbl_rd_idx;
  logic [PHY_WIDTH-1:0]       tbl_pos_x;
  logic [PHY_WIDTH-1:0]       tbl_pos_y;
  logic [BLOCK_LEN_WIDTH-1:0] tbl_block_width;

  modport master (
    output tbl_rd_en, tbl_rd_idx,
    input  tbl_pos_x, tbl_pos_y, tbl_block_width
  );

  modport slave (
    input  tbl_rd_en, tbl_rd_idx,
    output tbl_pos_x, tbl_pos_y, tbl_block_width
  );

endinterface

// File: rtl/obstacle_line_hit.sv
// Combinational test of one table entry against the scheduled line, plus row and pixel width.
module obstacle_line_hit #(
  parameter int PHY_WIDTH       = 14,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int OBSTACLE_WIDTH  = 10,
  parameter int OBSTACLE_HEIGHT = 20,
  parameter int ROW_WIDTH       = 5
) (
  input  logic [PHY_WIDTH-1:0]       abs_y,
  input  logic [PHY_WIDTH-1:0]       pos_y,
  input  logic [BLOCK_LEN_WIDTH-1:0] block_width,
  output logic                       hit,
  output logic [ROW_WIDTH-1:0]       row,
  output logic [PHY_WIDTH-1:0]       pix_w
);

  // Bottom edge is one bit wider so an obstacle near the top of the space cannot wrap.
  logic [PHY_WIDTH:0] y_end;

  assign y_end = {1'b0, pos_y} + (PHY_WIDTH+1)'(OBSTACLE_HEIGHT);
  assign hit   = (block_width != '0) && (abs_y >= pos_y) && ({1'b0, abs_y} < y_end);
  assign row   = ROW_WIDTH'(abs_y - pos_y);
  assign pix_w = PHY_WIDTH'(block_width) * PHY_WIDTH'(OBSTACLE_WIDTH);

endmodule

// File: rtl/obstacle_line_scheduler.sv
// Scans the obstacle table each line and packs hits into a shadow slot list swapped in on line_swap.
// Optional overflow-line counter enabled by defining OBSTACLE_SCHED_STATS_EN.
module obstacle_line_scheduler #(
  parameter int OBSTACLE_NUM    = 10,
  parameter int SLOT_NUM        = obstacle_sched_pkg::SLOT_NUM,
  parameter int PHY_WIDTH       = 14,
  parameter int SCREEN_WIDTH    = 10,
  parameter int BLOCK_LEN_WIDTH = 4,
  parameter int OBSTACLE_WIDTH  = obstacle_sched_pkg::OBSTACLE_WIDTH,
  parameter int OBSTACLE_HEIGHT = obstacle_sched_pkg::OBSTACLE_HEIGHT
) (
  input  logic                                          sys_clk,
  input  logic                                          sys_rst_n,
  input  logic                                          line_start,
  input  logic [SCREEN_WIDTH-1:0]                       next_y,
  input  logic [PHY_WIDTH-1:0]                          camera_offset,
  input  logic                                          line_swap,
  obstacle_line_scheduler_if.master                     tbl,
  output logic [SLOT_NUM-1:0]                           slot_valid,
  output logic [SLOT_NUM*PHY_WIDTH-1:0]                 slot_x,
  output logic [SLOT_NUM*PHY_WIDTH-1:0]                 slot_w,
  output logic [SLOT_NUM*obstacle_sched_pkg::ROW_WIDTH-1:0] slot_row,
  output logic [SLOT_NUM*obstacle_sched_pkg::ID_WIDTH-1:0]  slot_id,
  output logic                                          busy,
  output logic                                          line_ovf,
  output logic                                          swap_late,
  output logic [15:0]                                   ovf_count
);

  import obstacle_sched_pkg::*;

  localparam int IDX_W = $clog2(OBSTACLE_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OBSTACLE_NUM - 1);

  sched_state_t state_q, state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     ret_idx_q;
  logic                 ret_valid_q;
  logic [PHY_WIDTH-1:0] abs_y_q;

  logic                 hit;
  logic [ROW_WIDTH-1:0] hit_row;
  logic [PHY_WIDTH-1:0] hit_w;
  logic [SLOT_NUM-1:0]  free_onehot;
  logic                 free_taken;

  logic [SLOT_NUM-1:0]                 sh_valid, act_valid;
  logic [SLOT_NUM-1:0][PHY_WIDTH-1:0]  sh_x, sh_w, act_x, act_w;
  logic [SLOT_NUM-1:0][ROW_WIDTH-1:0]  sh_row, act_row;
  logic [SLOT_NUM-1:0][ID_WIDTH-1:0]   sh_id, act_id;
  logic                                sh_ovf, act_ovf;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // A new line_start restarts the scan from any state.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    unique case (state_q)
      IDLE:  if (line_start) state_d = ISSUE;
      ISSUE: begin
        busy = 1'b1;
        if (line_start)            state_d = ISSUE;
        else if (idx_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = line_start ? ISSUE : DONE;
      end
      DONE:  if (line_start) state_d = ISSUE;
      default: state_d = IDLE;
    endcase
  end

  assign tbl.tbl_rd_en  = (state_q == ISSUE);
  assign tbl.tbl_rd_idx = idx_q;

  // Returns in flight when a line restarts belong to the old line and are discarded.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_q       <= '0;
      ret_idx_q   <= '0;
      ret_valid_q <= 1'b0;
      abs_y_q     <= '0;
    end else begin
      ret_idx_q   <= idx_q;
      ret_valid_q <= tbl.tbl_rd_en && !line_start;
      if (line_start) begin
        idx_q   <= '0;
        abs_y_q <= PHY_WIDTH'(next_y) + camera_offset;
      end else if (state_q == ISSUE && idx_q != LAST_IDX) begin
        idx_q <= idx_q + 1'b1;
      end else begin
        idx_q <= '0;
      end
    end
  end

  obstacle_line_hit #(
    .PHY_WIDTH       (PHY_WIDTH),
    .BLOCK_LEN_WIDTH (BLOCK_LEN_WIDTH),
    .OBSTACLE_WIDTH  (OBSTACLE_WIDTH),
    .OBSTACLE_HEIGHT (OBSTACLE_HEIGHT),
    .ROW_WIDTH       (ROW_WIDTH)
  ) u_hit (
    .abs_y       (abs_y_q),
    .pos_y       (tbl.tbl_pos_y),
    .block_width (tbl.tbl_block_width),
    .hit         (hit),
    .row         (hit_row),
    .pix_w       (hit_w)
  );

  always_comb begin
    free_onehot = '0;
    free_taken  = 1'b0;
    for (int s = 0; s < SLOT_NUM; s++) begin
      if (!free_taken && !sh_valid[s]) begin
        free_onehot[s] = 1'b1;
        free_taken     = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sh_valid <= '0;
      sh_x     <= '0;
      sh_w     <= '0;
      sh_row   <= '0;
      sh_id    <= '0;
      sh_ovf   <= 1'b0;
    end else if (line_start) begin
      sh_valid <= '0;
      sh_ovf   <= 1'b0;
    end else if (ret_valid_q && hit) begin
      if (!free_taken) sh_ovf <= 1'b1;
      for (int s = 0; s < SLOT_NUM; s++) begin
        if (free_onehot[s]) begin
          sh_valid[s] <= 1'b1;
          sh_x[s]     <= tbl.tbl_pos_x;
          sh_w[s]     <= hit_w;
          sh_row[s]   <= hit_row;
          sh_id[s]    <= ID_WIDTH'(ret_idx_q);
        end
      end
    end
  end

  // Active list only moves on line_swap; a swap before the scan finishes blanks the line.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      act_valid <= '0;
      act_x     <= '0;
      act_w     <= '0;
      act_row   <= '0;
      act_id    <= '0;
      act_ovf   <= 1'b0;
      swap_late <= 1'b0;
    end else begin
      swap_late <= 1'b0;
      if (line_swap) begin
        if (state_q == DONE) begin
          act_valid <= sh_valid;
          act_x     <= sh_x;
          act_w     <= sh_w;
          act_row   <= sh_row;
          act_id    <= sh_id;
          act_ovf   <= sh_ovf;
        end else begin
          act_valid <= '0;
          act_ovf   <= 1'b0;
          swap_late <= 1'b1;
        end
      end
    end
  end

  assign slot_valid = act_valid;
  assign slot_x     = act_x;
  assign slot_w     = act_w;
  assign slot_row   = act_row;
  assign slot_id    = act_id;
  assign line_ovf   = act_ovf;

`ifdef OBSTACLE_SCHED_STATS_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      ovf_cnt_q <= '0;
    else if (line_swap && state_q == DONE && sh_ovf && ovf_cnt_q != 16'hFFFF)
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = 16'd0;
`endif

endmodule

// File: tb/tb_obstacle_line_scheduler.sv
// Directed bench for obstacle_line_scheduler: vector table of whole lines plus timing sequences.
module tb_obstacle_line_scheduler;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        line_start;
  logic [9:0]  next_y;
  logic [13:0] camera_offset;
  logic        line_swap;
  logic [3:0]  slot_valid;
  logic [55:0] slot_x;
  logic [55:0] slot_w;
  logic [19:0] slot_row;
  logic [15:0] slot_id;
  logic        busy;
  logic        line_ovf;
  logic        swap_late;
  logic [15:0] ovf_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

`ifdef OBSTACLE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  obstacle_line_scheduler_if #(.PHY_WIDTH(14), .BLOCK_LEN_WIDTH(4), .IDX_WIDTH(4)) tif ();

  obstacle_line_scheduler dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .line_start    (line_start),
    .next_y        (next_y),
    .camera_offset (camera_offset),
    .line_swap     (line_swap),
    .tbl           (tif.master),
    .slot_valid    (slot_valid),
    .slot_x        (slot_x),
    .slot_w        (slot_w),
    .slot_row      (slot_row),
    .slot_id       (slot_id),
    .busy          (busy),
    .line_ovf      (line_ovf),
    .swap_late     (swap_late),
    .ovf_count     (ovf_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [13:0] mem_x [0:15];
  logic [13:0] mem_y [0:15];
  logic [3:0]  mem_w [0:15];

  // Table model with one cycle of read latency
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tif.tbl_pos_x       <= '0;
      tif.tbl_pos_y       <= '0;
      tif.tbl_block_width <= '0;
    end else if (tif.tbl_rd_en) begin
      tif.tbl_pos_x       <= mem_x[tif.tbl_rd_idx];
      tif.tbl_pos_y       <= mem_y[tif.tbl_rd_idx];
      tif.tbl_block_width <= mem_w[tif.tbl_rd_idx];
    end
  end

  typedef struct {
    int          pat;
    logic [9:0]  ny;
    logic [13:0] cam;
    logic [3:0]  valid;
    logic        ovf;
    logic [3:0]  id0;
    logic [4:0]  row0;
    logic [13:0] w0;
    logic [3:0]  id3;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic loadTable(input int p);
    for (int i = 0; i < 16; i++) begin
      mem_x[i] = 14'(1000 + i);
      mem_y[i] = '0;
      mem_w[i] = '0;
    end
    case (p)
      0: begin mem_y[3] = 14'd90; mem_w[3] = 4'd2; end
      1: for (int i = 0; i < 6; i++) mem_w[i] = 4'd1;
      2: begin mem_y[0] = 14'd80; mem_w[0] = 4'd1; mem_y[1] = 14'd95; end
      3: mem_w[0] = 4'd3;
      default: ;
    endcase
  endtask

  task automatic startLine(input logic [9:0] ny, input logic [13:0] cam);
    @(negedge sys_clk);
    line_start    = 1'b1;
    next_y        = ny;
    camera_offset = cam;
    @(negedge sys_clk);
    line_start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    for (int c = 0; c < 40 && busy; c++) @(negedge sys_clk);
    checkOutput(name, busy, 1'b0);
  endtask

  task automatic doSwap();
    line_swap = 1'b1;
    @(negedge sys_clk);
    line_swap = 1'b0;
  endtask

  task automatic checkList(input string tag, input vec_t v);
    checkOutput({tag, "_valid"}, slot_valid, v.valid);
    checkOutput({tag, "_ovf"}, line_ovf, v.ovf);
    checkOutput({tag, "_ovf_count"}, ovf_count, exp_cnt);
    if (v.valid[0]) begin
      checkOutput({tag, "_id0"}, slot_id[3:0], v.id0);
      checkOutput({tag, "_row0"}, slot_row[4:0], v.row0);
      checkOutput({tag, "_w0"}, slot_w[13:0], v.w0);
      checkOutput({tag, "_x0"}, slot_x[13:0], 14'(1000 + v.id0));
    end
    if (v.valid[3]) checkOutput({tag, "_id3"}, slot_id[15:12], v.id3);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    loadTable(v.pat);
    startLine(v.ny, v.cam);
    waitDone({tag, "_done"});
    doSwap();
    if (STATS && v.ovf) exp_cnt++;
    checkList(tag, v);
  endtask

  initial begin
    vec_t v;
    sys_rst_n = 1'b0;
    line_start = 1'b0;
    line_swap = 1'b0;
    next_y = '0;
    camera_offset = '0;
    loadTable(-1);

    vecs[0] = '{0, 10'd100, 14'd0,     4'b0001, 1'b0, 4'd3, 5'd10, 14'd20, 4'd0};
    vecs[1] = '{1, 10'd5,   14'd0,     4'b1111, 1'b1, 4'd0, 5'd5,  14'd10, 4'd3};
    vecs[2] = '{2, 10'd100, 14'd0,     4'b0000, 1'b0, 4'd0, 5'd0,  14'd0,  4'd0};
    vecs[3] = '{3, 10'd10,  14'd16380, 4'b0001, 1'b0, 4'd0, 5'd6,  14'd30, 4'd0};
    vecs[4] = '{0, 10'd109, 14'd0,     4'b0001, 1'b0, 4'd3, 5'd19, 14'd20, 4'd0};
    vecs[5] = '{0, 10'd89,  14'd0,     4'b0000, 1'b0, 4'd0, 5'd0,  14'd0,  4'd0};
    vecs[6] = '{0, 10'd110, 14'd0,     4'b0000, 1'b0, 4'd0, 5'd0,  14'd0,  4'd0};
    vecs[7] = '{2, 10'd99,  14'd0,     4'b0001, 1'b0, 4'd0, 5'd19, 14'd10, 4'd0};

    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    checkOutput("rst_rd_en", tif.tbl_rd_en, 1'b0);
    checkOutput("rst_rd_idx", tif.tbl_rd_idx, 4'd0);
    checkOutput("rst_valid", slot_valid, 4'd0);
    checkOutput("rst_slot_fields", {slot_x, slot_w}, 112'd0);
    checkOutput("rst_row_id", {slot_row, slot_id}, 36'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_flags", {line_ovf, swap_late}, 2'b00);
    checkOutput("rst_ovf_count", ovf_count, 16'd0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Swap lands at cycle 5 of a scan: active list blanks, scan still finishes on time
    loadTable(0);
    @(negedge sys_clk);
    line_start = 1'b1; next_y = 10'd100; camera_offset = 14'd0;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge sys_clk);
      if (cyc == 1) begin
        line_start = 1'b0;
        checkOutput("late_rd_en_c1", tif.tbl_rd_en, 1'b1);
        checkOutput("late_busy_c1", busy, 1'b1);
      end
      if (cyc == 5) line_swap = 1'b1;
      if (cyc == 6) begin
        line_swap = 1'b0;
        checkOutput("late_pulse", swap_late, 1'b1);
        checkOutput("late_valid", slot_valid, 4'd0);
        checkOutput("late_busy_c6", busy, 1'b1);
      end
      if (cyc == 7)  checkOutput("late_pulse_end", swap_late, 1'b0);
      if (cyc == 10) checkOutput("late_idx_c10", {tif.tbl_rd_en, tif.tbl_rd_idx}, {1'b1, 4'd9});
      if (cyc == 11) checkOutput("late_drain_c11", {tif.tbl_rd_en, busy}, 2'b01);
      if (cyc == 12) checkOutput("late_done_c12", busy, 1'b0);
    end
    doSwap();
    checkList("late_commit", vecs[0]);

    // Restart at cycle 4: entry 3 read in that cycle must not leak into the new list
    loadTable(0);
    @(negedge sys_clk);
    line_start = 1'b1; next_y = 10'd200; camera_offset = 14'd0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge sys_clk);
      if (cyc == 1) line_start = 1'b0;
      if (cyc == 3) checkOutput("rst_scan_idx_c3", tif.tbl_rd_idx, 4'd2);
      if (cyc == 4) begin line_start = 1'b1; next_y = 10'd95; end
      if (cyc == 5) begin
        line_start = 1'b0;
        checkOutput("restart_idx", {tif.tbl_rd_en, tif.tbl_rd_idx}, {1'b1, 4'd0});
      end
      if (cyc == 15) checkOutput("restart_busy_c15", busy, 1'b1);
      if (cyc == 16) checkOutput("restart_done_c16", busy, 1'b0);
    end
    doSwap();
    v = '{0, 10'd95, 14'd0, 4'b0001, 1'b0, 4'd3, 5'd5, 14'd20, 4'd0};
    checkList("restart", v);

    // Swap and start together: old shadow commits while the next scan begins
    loadTable(1);
    startLine(10'd5, 14'd0);
    waitDone("both_first_done");
    loadTable(0);
    line_swap = 1'b1; line_start = 1'b1; next_y = 10'd100;
    @(negedge sys_clk);
    line_swap = 1'b0; line_start = 1'b0;
    if (STATS) exp_cnt++;
    checkList("both_commit", vecs[1]);
    checkOutput("both_scan_begins", {tif.tbl_rd_en, tif.tbl_rd_idx, busy}, {1'b1, 4'd0, 1'b1});
    checkOutput("both_no_late", swap_late, 1'b0);
    waitDone("both_second_done");
    doSwap();
    checkList("both_second", vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
